// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical registers: zero-latency head read for rename, up to 2 releases/cycle from retire.
// No backpressure; underflow, illegal release_count and overflow drop the offending ops and set a sticky error.
module phys_reg_free_list #(
  parameter int PREG_COUNT = 64,
  parameter int AREG_COUNT = 32,
  parameter int LIST_DEPTH = PREG_COUNT - AREG_COUNT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_req,
  output logic [$clog2(PREG_COUNT)-1:0] alloc_preg,
  output logic                          alloc_valid,
  input  logic [1:0]                    release_count,
  input  logic [$clog2(PREG_COUNT)-1:0] release_preg0,
  input  logic [$clog2(PREG_COUNT)-1:0] release_preg1,
  output logic [$clog2(LIST_DEPTH+1)-1:0] free_count,
  output logic                          error
);

  localparam int IW = $clog2(PREG_COUNT);
  localparam int PW = $clog2(LIST_DEPTH);
  localparam int CW = $clog2(LIST_DEPTH + 1);

  logic [IW-1:0] r_entry [LIST_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_error;

  logic          w_pop;
  logic          w_underflow;
  logic          w_illegal;
  logic          w_v0;
  logic          w_v1;
  logic          w_overflow;
  logic [1:0]    w_req;
  logic [1:0]    w_acc;
  logic [CW:0]   w_room;
  logic [IW-1:0] w_d0;

  assign w_pop       = alloc_req && (r_count != '0);
  assign w_underflow = alloc_req && (r_count == '0);
  assign w_illegal   = (release_count == 2'd3);

  // p0 is hard-wired x0 and must never re-enter the pool.
  assign w_v0  = !w_illegal && (release_count != 2'd0) && (release_preg0 != '0);
  assign w_v1  = !w_illegal && (release_count == 2'd2) && (release_preg1 != '0);
  assign w_req = {1'b0, w_v0} + {1'b0, w_v1};
  assign w_d0  = w_v0 ? release_preg0 : release_preg1;

  // Space left after this cycle's pop; the popped slot can be refilled at once.
  assign w_room = (CW+1)'(LIST_DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_pop};

  always_comb begin
    w_overflow = 1'b0;
    w_acc      = w_req;
    if ({{(CW-1){1'b0}}, w_req} > w_room) begin
      w_overflow = 1'b1;
      w_acc      = w_room[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LIST_DEPTH; i++) begin
        r_entry[i] <= IW'(AREG_COUNT + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CW'(LIST_DEPTH);
      r_error <= 1'b0;
    end else begin
      if (w_acc != 2'd0) begin
        r_entry[r_tail] <= w_d0;
      end
      if (w_acc == 2'd2) begin
        r_entry[r_tail + PW'(1)] <= release_preg1;
      end
      r_head  <= r_head + {{(PW-1){1'b0}}, w_pop};
      r_tail  <= r_tail + PW'(w_acc);
      r_count <= r_count - {{(CW-1){1'b0}}, w_pop} + {{(CW-2){1'b0}}, w_acc};
      r_error <= r_error | w_underflow | w_illegal | w_overflow;
    end
  end

  assign alloc_preg  = r_entry[r_head];
  assign alloc_valid = (r_count != '0);
  assign free_count  = r_count;
  assign error       = r_error;

endmodule
